encrypt_driver: RTL and testbench

- Handshake adaptor that sits directly upstream and downstream of the iterative block cipher core (`encrypt_v2`).
- Accepts plaintext blocks on a valid/ready stream and buffers them in a small FIFO.
- Drives the core's level-sensitive req/ack protocol one block at a time, then presents ciphertext on an output valid/ready stream.
- Holds the active key in a register, loaded through a dedicated strobe.

---
 rtl/encrypt_driver_if.sv | 50 +++++
 rtl/encrypt_driver.sv | 193 +++++++++++++++++++
 tb/tb_encrypt_driver.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encrypt_driver_if.sv
// Stream, key and core-side signals of encrypt_driver, bundled for port use.
// ENCRYPT_DRIVER_CBC_EN adds the iv_in/iv_ld chaining-value load.
`ifndef N_B
`define N_B 16
`endif
`ifndef N_K
`define N_K 16
`endif
`ifndef N_R
`define N_R 8
`endif

interface encrypt_driver_if;
  logic [`N_K-1:0] key_in;
  logic            key_ld;
  logic [`N_B-1:0] in_m;
  logic            in_valid;
  logic            in_ready;
  logic [`N_B-1:0] out_c;
  logic            out_valid;
  logic            out_ready;
  logic [`N_B-1:0] enc_m;
  logic [`N_K-1:0] enc_k;
  logic            enc_req;
  logic [`N_B-1:0] enc_c;
  logic            enc_ack;
  logic            busy;
`ifdef ENCRYPT_DRIVER_CBC_EN
  logic [`N_B-1:0] iv_in;
  logic            iv_ld;

  modport master (
    output key_in, key_ld, in_m, in_valid, out_ready, enc_c, enc_ack, iv_in, iv_ld,
    input  in_ready, out_c, out_valid, enc_m, enc_k, enc_req, busy
  );
  modport slave (
    input  key_in, key_ld, in_m, in_valid, out_ready, enc_c, enc_ack, iv_in, iv_ld,
    output in_ready, out_c, out_valid, enc_m, enc_k, enc_req, busy
  );
`else
  modport master (
    output key_in, key_ld, in_m, in_valid, out_ready, enc_c, enc_ack,
    input  in_ready, out_c, out_valid, enc_m, enc_k, enc_req, busy
  );
  modport slave (
    input  key_in, key_ld, in_m, in_valid, out_ready, enc_c, enc_ack,
    output in_ready, out_c, out_valid, enc_m, enc_k, enc_req, busy
  );
`endif
endinterface

// File: rtl/encrypt_driver.sv
// Valid/ready adaptor around the iterative cipher core: input FIFO, req/ack FSM, output register.
// Define ENCRYPT_DRIVER_CBC_EN to chain blocks (CBC) through an IV/ciphertext register.
module encrypt_driver #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  encrypt_driver_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [`N_B-1:0] fifo_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r;
  logic [`N_K-1:0] key_r, key_pend_val_r;
  logic            key_pend_r;
  logic [`N_B-1:0] out_c_r, enc_m_r, head_s;
  logic            out_valid_r, enc_req_r;
  logic            in_ready_s, push_s, pop_s, capture_s, idle_s;

  assign idle_s     = (state_r == IDLE);
  assign in_ready_s = (count_r != FULL_CNT);
  assign push_s     = bus.in_valid && in_ready_s;

`ifdef ENCRYPT_DRIVER_CBC_EN
  logic [`N_B-1:0] chain_r, iv_pend_val_r, chain_eff_s;
  logic            iv_pend_r;

  // A parked IV must already govern the very pop that coincides with its release.
  assign chain_eff_s = iv_pend_r ? iv_pend_val_r : chain_r;
  assign head_s      = fifo_mem_r[rd_ptr_r] ^ chain_eff_s;

  // Chain register: IV loads (deferred outside IDLE) or the last captured ciphertext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r       <= {`N_B{1'b0}};
      iv_pend_val_r <= {`N_B{1'b0}};
      iv_pend_r     <= 1'b0;
    end else if (bus.iv_ld && idle_s) begin
      chain_r   <= bus.iv_in;
      iv_pend_r <= 1'b0;
    end else if (bus.iv_ld) begin
      iv_pend_val_r <= bus.iv_in;
      iv_pend_r     <= 1'b1;
    end else if (iv_pend_r && idle_s) begin
      chain_r   <= iv_pend_val_r;
      iv_pend_r <= 1'b0;
    end else if (capture_s) begin
      chain_r <= bus.enc_c;
    end
  end
`else
  assign head_s = fifo_mem_r[rd_ptr_r];
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_c     = out_c_r;
  assign bus.out_valid = out_valid_r;
  assign bus.enc_m     = enc_m_r;
  assign bus.enc_k     = key_r;
  assign bus.enc_req   = enc_req_r;
  assign bus.busy      = (count_r != ZERO_CNT) || !idle_s || out_valid_r;

  // Next-state logic; a launch waits for an empty output register and a quiet ack line.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if ((count_r != ZERO_CNT) && !out_valid_r && !bus.enc_ack) begin
          pop_s       = 1'b1;
          state_nxt_s = LAUNCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LAUNCH: begin
        state_nxt_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.enc_ack) begin
          capture_s   = 1'b1;
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      RELEASE: begin
        if (!bus.enc_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; only slots below count_r are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.in_m;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Launch/capture datapath: enc_m on pop, req for the core, ciphertext holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_m_r     <= {`N_B{1'b0}};
      out_c_r     <= {`N_B{1'b0}};
      out_valid_r <= 1'b0;
      enc_req_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        enc_m_r <= head_s;
      end
      if (state_r == LAUNCH) begin
        enc_req_r <= 1'b1;
      end else if (capture_s) begin
        enc_req_r <= 1'b0;
      end
      if (capture_s) begin
        out_c_r     <= bus.enc_c;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Key register: loads outside IDLE are parked so enc_k never moves under an active req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r          <= {`N_K{1'b0}};
      key_pend_val_r <= {`N_K{1'b0}};
      key_pend_r     <= 1'b0;
    end else if (bus.key_ld && idle_s) begin
      key_r      <= bus.key_in;
      key_pend_r <= 1'b0;
    end else if (bus.key_ld) begin
      key_pend_val_r <= bus.key_in;
      key_pend_r     <= 1'b1;
    end else if (key_pend_r && idle_s) begin
      key_r      <= key_pend_val_r;
      key_pend_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_encrypt_driver.sv
// Directed bench for encrypt_driver with a stand-in cipher core and a scoreboard of expected ciphertexts.
`ifndef N_B
`define N_B 16
`endif
`ifndef N_K
`define N_K 16
`endif
`ifndef N_R
`define N_R 8
`endif

module tb_encrypt_driver;
  localparam int DEPTH = 4;
  localparam int NR    = `N_R;
  localparam logic [`N_B-1:0] CMASK = {(`N_B/8){8'h5A}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  logic [`N_B-1:0] exp_q[$];
  int              rise_cyc[$];
  logic [`N_B-1:0] launch_m[$];
  logic [`N_K-1:0] key_m = '0;
`ifdef ENCRYPT_DRIVER_CBC_EN
  logic [`N_B-1:0] chain_m = '0;
`endif
  int              last_push_cyc = 0;

  encrypt_driver_if bus ();
  encrypt_driver #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference cipher: rotate left by the round count, then mix in key and a fixed mask.
  function automatic logic [`N_B-1:0] cipher(input logic [`N_B-1:0] m, input logic [`N_K-1:0] k);
    logic [`N_B-1:0] x;
    x = m;
    for (int r = 0; r < NR; r++) x = {x[`N_B-2:0], x[`N_B-1]};
    for (int i = 0; i < `N_B; i++) x[i] = x[i] ^ k[i % `N_K] ^ CMASK[i];
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not reached within its cycle budget", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ciphertext of the next block in stream order.
  task automatic model_exp(input logic [`N_B-1:0] m, output logic [`N_B-1:0] c);
`ifdef ENCRYPT_DRIVER_CBC_EN
    c = cipher(m ^ chain_m, key_m);
    chain_m = c;
`else
    c = cipher(m, key_m);
`endif
    exp_q.push_back(c);
  endtask

  // Stand-in for the core: samples m/k on the first edge req is seen, acks so the
  // driver samples ack high NR+1 edges after the req rise, drops ack once req falls.
  logic [`N_B-1:0] core_m;
  logic [`N_K-1:0] core_k;
  logic            core_busy;
  int              core_rem;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.enc_ack <= 1'b0;
      bus.enc_c   <= '0;
      core_busy   <= 1'b0;
      core_rem    <= 0;
    end else if (core_busy) begin
      if (core_rem == 1) begin
        bus.enc_ack <= 1'b1;
        bus.enc_c   <= cipher(core_m, core_k);
        core_busy   <= 1'b0;
      end else begin
        core_rem <= core_rem - 1;
      end
    end else if (bus.enc_ack) begin
      if (!bus.enc_req) bus.enc_ack <= 1'b0;
    end else if (bus.enc_req) begin
      core_m    <= bus.enc_m;
      core_k    <= bus.enc_k;
      core_busy <= 1'b1;
      core_rem  <= NR - 1;
    end
  end

  // Compare process: every accepted output against the scoreboard; enc_k frozen under req.
  logic            prev_req = 1'b0;
  logic            prev_ov  = 1'b0;
  logic [`N_K-1:0] k_at_rise = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req <= 1'b0;
      prev_ov  <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) rise_cyc.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out_c", bus.out_c, 64'hDEAD_0000_0000_0000);
        else check("out_c", bus.out_c, exp_q.pop_front());
      end
      if (bus.enc_req && !prev_req) begin
        k_at_rise <= bus.enc_k;
        launch_m.push_back(bus.enc_m);
      end else if (bus.enc_req) begin
        check("enc_k_hold", bus.enc_k, k_at_rise);
      end
      prev_req <= bus.enc_req;
      prev_ov  <= bus.out_valid;
    end
  end

  task automatic push_blk(input logic [`N_B-1:0] m);
    int g = 0;
    logic [`N_B-1:0] c;
    bus.in_m     = m;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && g < 200) begin tick(); g++; end
    if (!bus.in_ready) timeout("push_wait");
    last_push_cyc = cyc;
    tick();
    model_exp(m, c);
  endtask

  task automatic wait_req();
    int g = 0;
    while (!bus.enc_req && g < 100) begin tick(); g++; end
    if (!bus.enc_req) timeout("wait_req");
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.busy) && g < 500) begin tick(); g++; end
    if (exp_q.size() != 0 || bus.busy) timeout("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, low, t0, n0, pushed;
    logic seen_req, took;
    logic [`N_B-1:0] held, v, c;
    logic [`N_B-1:0] m1_exp;

    bus.key_in = '0; bus.key_ld = 1'b0; bus.in_m = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
`ifdef ENCRYPT_DRIVER_CBC_EN
    bus.iv_in = '0; bus.iv_ld = 1'b0;
`endif
    tick(); tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_enc_req", bus.enc_req, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_c", bus.out_c, 0);
    check("rst_enc_m", bus.enc_m, 0);
    check("rst_enc_k", bus.enc_k, 0);
    rst_n = 1'b1;
    tick();

    // Key load, single block, latency counted from the edge that opens the push cycle.
    bus.key_in = 16'h0F0F; bus.key_ld = 1'b1; tick(); bus.key_ld = 1'b0; key_m = 16'h0F0F;
    check("enc_k_loaded", bus.enc_k, 16'h0F0F);
    push_blk(16'h1234);
    bus.in_valid = 1'b0;
    seen_req = 1'b0; lat = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      if (bus.enc_req && !seen_req) begin
        seen_req = 1'b1;
        check("enc_k_at_req", bus.enc_k, 16'h0F0F);
      end
      if (bus.out_valid) lat = cyc - last_push_cyc;
      else tick();
    end
    check("latency", lat, NR + 4);
    check("out_c_literal", bus.out_c, 16'h6147);
    wait_drain();

    // DEPTH+1 back-to-back pushes: no stall, then full for exactly NR+2 samples.
    rise_cyc.delete();
    n0 = n_out;
    t0 = cyc;
    v  = 16'h1000;
    for (int i = 0; i <= DEPTH; i++) begin
      push_blk(v);
      v = v + 16'h0001;
    end
    bus.in_valid = 1'b0;
    check("push_cycles", cyc - t0, DEPTH + 1);
    check("in_ready_full", bus.in_ready, 0);
    low = 0;
    while (!bus.in_ready && low < 200) begin low++; tick(); end
    check("full_samples", low, NR + 2);
    wait_drain();
    check("fifo_out_count", n_out - n0, DEPTH + 1);
    check("rise_count", rise_cyc.size(), DEPTH + 1);
    for (int i = 1; i < rise_cyc.size(); i++) check("throughput", rise_cyc[i] - rise_cyc[i-1], NR + 5);

    // Output stalled for 20 clocks: result held, no launch, FIFO fills.
    bus.out_ready = 1'b0;
    push_blk(16'h2000);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 60 && !bus.out_valid; i++) tick();
    if (!bus.out_valid) timeout("stall_first_result");
    held   = bus.out_c;
    pushed = 0;
    for (int i = 0; i < 20; i++) begin
      took = 1'b0;
      if (bus.in_ready && pushed < DEPTH) begin
        v = 16'h2100 + 16'(pushed);
        bus.in_m = v; bus.in_valid = 1'b1; took = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (took) begin model_exp(v, c); pushed++; end
      check("stall_out_c", bus.out_c, held);
      check("stall_enc_req", bus.enc_req, 0);
      check("stall_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    check("stall_pushed", pushed, DEPTH);
    check("stall_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    wait_drain();

    // Key load during WAIT_ACK is deferred to the next block.
    push_blk(16'h0001);
    bus.in_valid = 1'b0;
    wait_req();
    tick(); tick();
    bus.key_in = 16'h00F0; bus.key_ld = 1'b1; tick(); bus.key_ld = 1'b0; key_m = 16'h00F0;
    check("enc_k_deferred", bus.enc_k, 16'h0F0F);
    push_blk(16'h0002);
    bus.in_valid = 1'b0;
    wait_drain();
    check("enc_k_applied", bus.enc_k, 16'h00F0);

    // Reset three clocks into WAIT_ACK.
    push_blk(16'h0BEE);
    bus.in_valid = 1'b0;
    wait_req();
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_enc_req", bus.enc_req, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    exp_q.delete();
    key_m = '0;
`ifdef ENCRYPT_DRIVER_CBC_EN
    chain_m = '0;
`endif
    tick();
    rst_n = 1'b1;
    tick();
    n0 = n_out;
    push_blk(16'h0C0D);
    bus.in_valid = 1'b0;
    wait_drain();
    check("post_rst_out_count", n_out - n0, 1);

    // Chaining: second enc_m is the block XOR the first ciphertext (CBC) or the raw block (ECB).
`ifdef ENCRYPT_DRIVER_CBC_EN
    bus.iv_in = 16'hAAAA; bus.iv_ld = 1'b1; tick(); bus.iv_ld = 1'b0; chain_m = 16'hAAAA;
    m1_exp = 16'hF1F2;
`else
    m1_exp = 16'h0002;
`endif
    launch_m.delete();
    push_blk(16'h0001);
    push_blk(16'h0002);
    bus.in_valid = 1'b0;
    wait_drain();
    check("launch_count", launch_m.size(), 2);
    if (launch_m.size() == 2) check("second_enc_m", launch_m[1], m1_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
